fakeram130_64x7_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one single-port 64x7 fakeram macro among NUM_REQ requesters.
- Each requester issues masked writes or reads over a valid/ready handshake and receives read data through its own 1-entry response buffer, which has valid/yumi backpressure.
- Sits directly in front of the macro instance. It drives the macro's ce/we/addr/wd/w_mask pins and captures its rd_out.

---
 rtl/fakeram130_64x7_arb.sv | 120 ++++++++++++
 tb/tb_fakeram130_64x7_arb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fakeram130_64x7_arb.sv
// Round-robin arbiter and sequencer sharing one single-port 64x7 fakeram
// macro among NUM_REQ requesters. Writes are fire-and-forget. Read data
// returns through a 1-entry response buffer per requester.
`timescale 1ns/1ps
module fakeram130_64x7_arb #(
  parameter int NUM_REQ    = 2,
  parameter int BITS       = 7,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_v_i,
  input  logic [NUM_REQ-1:0]               req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [NUM_REQ*BITS-1:0]          req_data_i,
  input  logic [NUM_REQ*BITS-1:0]          req_mask_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  output logic [NUM_REQ-1:0]               resp_v_o,
  output logic [NUM_REQ*BITS-1:0]          resp_data_o,
  input  logic [NUM_REQ-1:0]               resp_yumi_i,
  output logic                             ram_ce_o,
  output logic                             ram_we_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic [BITS-1:0]                  ram_wd_o,
  output logic [BITS-1:0]                  ram_w_mask_o,
  input  logic [BITS-1:0]                  ram_rd_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] pending_q;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  int                 idx;

  // Eligibility: writes always, reads only when the response path is free.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block can leave it holding a stale value.
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = !reset && req_v_i[i] &&
                (req_we_i[i] ||
                 (!pending_q[i] && (!resp_v_o[i] || resp_yumi_i[i])));
    end
  end

  // Round-robin pick: first eligible requester at or after the pointer.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(idx);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready_o = gnt;
  assign ptr_d       = gnt_any ? PTR_W'((int'(gnt_idx) + 1) % NUM_REQ) : ptr_q;

  // Macro pins follow the granted request; all zero when idle.
  always_comb begin
    ram_ce_o     = gnt_any;
    ram_we_o     = 1'b0;
    ram_addr_o   = '0;
    ram_wd_o     = '0;
    ram_w_mask_o = '0;
    if (gnt_any) begin
      ram_we_o     = req_we_i[gnt_idx];
      ram_addr_o   = req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      ram_wd_o     = req_data_i[gnt_idx*BITS +: BITS];
      ram_w_mask_o = req_mask_i[gnt_idx*BITS +: BITS];
    end
  end

  // Pointer, one-cycle pending-read flags and per-requester response buffers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      pending_q   <= '0;
      resp_v_o    <= '0;
      resp_data_o <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      ptr_q     <= ptr_d;
      pending_q <= gnt & ~req_we_i;
      for (int i = 0; i < NUM_REQ; i++) begin
        // A capture in the same edge as a yumi keeps the buffer full.
        if (pending_q[i]) begin
          resp_v_o[i]                  <= 1'b1;
          resp_data_o[i*BITS +: BITS]  <= ram_rd_i;
        end else if (resp_yumi_i[i]) begin
          resp_v_o[i] <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  // Consumers may only accept a response that is actually there.
  a_yumi_needs_v: assert property (@(posedge clk) disable iff (reset)
    (resp_yumi_i & ~resp_v_o) == '0);

  // At most one requester is granted per cycle.
  a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
    $onehot0(req_ready_o));
`endif

endmodule

// File: tb/tb_fakeram130_64x7_arb.sv
// Self-checking bench for fakeram130_64x7_arb: directed vector table,
// hand-written multi-cycle sequences and a randomized phase checked against
// a memory/queue reference model.
`timescale 1ns/1ps
module tb_fakeram130_64x7_arb;

  localparam int N  = 2;
  localparam int B  = 7;
  localparam int AW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_v, req_we, req_ready, resp_v, resp_yumi;
  logic [N*AW-1:0] req_addr;
  logic [N*B-1:0]  req_data, req_mask, resp_data;
  logic            ram_ce, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [B-1:0]    ram_wd, ram_w_mask, ram_rd;

  int n_chk = 0;
  int n_err = 0;

  fakeram130_64x7_arb #(.NUM_REQ(N), .BITS(B), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_v_i      (req_v),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_mask_i   (req_mask),
    .req_ready_o  (req_ready),
    .resp_v_o     (resp_v),
    .resp_data_o  (resp_data),
    .resp_yumi_i  (resp_yumi),
    .ram_ce_o     (ram_ce),
    .ram_we_o     (ram_we),
    .ram_addr_o   (ram_addr),
    .ram_wd_o     (ram_wd),
    .ram_w_mask_o (ram_w_mask),
    .ram_rd_i     (ram_rd)
  );

  always #5 clk = ~clk;

  // Behavioural single-port macro: masked write, or read data next cycle.
  logic [B-1:0] macro_mem [64];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) macro_mem[ram_addr] <= (macro_mem[ram_addr] & ~ram_w_mask) | (ram_wd & ram_w_mask);
      else        ram_rd <= macro_mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    req_v = '0; req_we = '0; req_addr = '0; req_data = '0; req_mask = '0; resp_yumi = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [B-1:0] d, input logic [B-1:0] m);
    req_v[i] = v; req_we[i] = we;
    req_addr[i*AW +: AW] = a; req_data[i*B +: B] = d; req_mask[i*B +: B] = m;
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle of requester-1 traffic with checks on grant and response buffer 1.
  task automatic r1_step(input string tag, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [B-1:0] d, input logic y, input logic [1:0] e_rdy,
                         input logic e_rv, input logic [B-1:0] e_rd);
    idle_all();
    set_req(1, v, we, a, d, 7'h7F);
    resp_yumi[1] = y;
    #1;
    check({tag, "_ready"}, req_ready, e_rdy);
    check({tag, "_resp_v1"}, resp_v[1], e_rv);
    if (e_rv) check({tag, "_resp_d1"}, resp_data[B +: B], e_rd);
    if (e_rdy != 2'b00) check({tag, "_ram_addr"}, ram_addr, a);
    @(negedge clk);
  endtask

  typedef struct {
    logic         v;
    logic         we;
    logic [AW-1:0] a;
    logic [B-1:0] d;
    logic [B-1:0] m;
    logic         y;
    logic [1:0]   rdy;
    logic         rwe;
    logic [AW-1:0] raddr;
    logic         rv;
    logic [B-1:0] rd;
  } vec_t;

  typedef struct {
    int           req;
    logic [B-1:0] data;
  } rd_t;

  vec_t         tbl [10];
  rd_t          inflight [$];
  rd_t          popped;
  logic [B-1:0] model_mem [64];
  logic         m_v [N];
  logic [B-1:0] m_d [N];
  logic [N-1:0] el, delivered;
  int           rr, g, j;
  logic [AW-1:0] ga;
  logic [B-1:0]  gd, gm;

  initial begin
    reset = 1'b1;
    idle_all();
    repeat (2) @(negedge clk);
    #1;
    check("rst_resp_v", resp_v, 2'b00);
    check("rst_resp_data", resp_data, 14'h0);
    check("rst_ce", ram_ce, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Write-then-read and partial-mask cases for requester 0, one row per cycle.
    tbl[0] = '{1'b1, 1'b1, 6'd5, 7'h5A, 7'h7F, 1'b0, 2'b01, 1'b1, 6'd5, 1'b0, 7'h00};
    tbl[1] = '{1'b1, 1'b0, 6'd5, 7'h00, 7'h00, 1'b0, 2'b01, 1'b0, 6'd5, 1'b0, 7'h00};
    tbl[2] = '{1'b0, 1'b0, 6'd0, 7'h00, 7'h00, 1'b0, 2'b00, 1'b0, 6'd0, 1'b0, 7'h00};
    tbl[3] = '{1'b0, 1'b0, 6'd0, 7'h00, 7'h00, 1'b1, 2'b00, 1'b0, 6'd0, 1'b1, 7'h5A};
    tbl[4] = '{1'b1, 1'b1, 6'd9, 7'h7F, 7'h7F, 1'b0, 2'b01, 1'b1, 6'd9, 1'b0, 7'h00};
    tbl[5] = '{1'b1, 1'b1, 6'd9, 7'h00, 7'h0F, 1'b0, 2'b01, 1'b1, 6'd9, 1'b0, 7'h00};
    tbl[6] = '{1'b1, 1'b0, 6'd9, 7'h00, 7'h00, 1'b0, 2'b01, 1'b0, 6'd9, 1'b0, 7'h00};
    tbl[7] = '{1'b0, 1'b0, 6'd0, 7'h00, 7'h00, 1'b0, 2'b00, 1'b0, 6'd0, 1'b0, 7'h00};
    tbl[8] = '{1'b0, 1'b0, 6'd0, 7'h00, 7'h00, 1'b1, 2'b00, 1'b0, 6'd0, 1'b1, 7'h70};
    tbl[9] = '{1'b0, 1'b0, 6'd0, 7'h00, 7'h00, 1'b0, 2'b00, 1'b0, 6'd0, 1'b0, 7'h00};
    for (int i = 0; i < 10; i++) begin
      idle_all();
      set_req(0, tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].m);
      resp_yumi[0] = tbl[i].y;
      #1;
      check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].rdy);
      check($sformatf("tbl%0d_ce", i), ram_ce, |tbl[i].rdy);
      check($sformatf("tbl%0d_we", i), ram_we, tbl[i].rwe);
      check($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].raddr);
      check($sformatf("tbl%0d_wd", i), ram_wd, (|tbl[i].rdy) ? tbl[i].d : 7'h00);
      check($sformatf("tbl%0d_mask", i), ram_w_mask, (|tbl[i].rdy) ? tbl[i].m : 7'h00);
      check($sformatf("tbl%0d_resp_v", i), resp_v, {1'b0, tbl[i].rv});
      if (tbl[i].rv) check($sformatf("tbl%0d_resp_d0", i), resp_data[B-1:0], tbl[i].rd);
      @(negedge clk);
    end

    // Contention right after reset: grants alternate starting at requester 0.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle_all();
      set_req(0, 1'b1, 1'b1, 6'd10, 7'h01, 7'h7F);
      set_req(1, 1'b1, 1'b1, 6'd20, 7'h02, 7'h7F);
      #1;
      check($sformatf("cont%0d_ready", c), req_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("cont%0d_addr", c), ram_addr, (c % 2 == 0) ? 6'd10 : 6'd20);
      @(negedge clk);
    end

    // Backpressure on requester 1: a full response buffer blocks reads, not writes.
    r1_step("bp_w",      1'b1, 1'b1, 6'd3, 7'h33, 1'b0, 2'b10, 1'b0, 7'h00);
    r1_step("bp_r",      1'b1, 1'b0, 6'd3, 7'h00, 1'b0, 2'b10, 1'b0, 7'h00);
    r1_step("bp_pend",   1'b1, 1'b0, 6'd3, 7'h00, 1'b0, 2'b00, 1'b0, 7'h00);
    r1_step("bp_full",   1'b1, 1'b0, 6'd3, 7'h00, 1'b0, 2'b00, 1'b1, 7'h33);
    r1_step("bp_wr_ok",  1'b1, 1'b1, 6'd4, 7'h11, 1'b0, 2'b10, 1'b1, 7'h33);
    r1_step("bp_hold",   1'b1, 1'b0, 6'd3, 7'h00, 1'b0, 2'b00, 1'b1, 7'h33);
    r1_step("bp_yumi",   1'b1, 1'b0, 6'd3, 7'h00, 1'b1, 2'b10, 1'b1, 7'h33);
    r1_step("bp_gap",    1'b0, 1'b0, 6'd0, 7'h00, 1'b0, 2'b00, 1'b0, 7'h00);
    r1_step("bp_resp",   1'b0, 1'b0, 6'd0, 7'h00, 1'b0, 2'b00, 1'b1, 7'h33);

    // Back-to-back read with yumi on the grant cycle returns the freshly written word.
    // A same-edge yumi and capture for one requester cannot arise from legal traffic,
    // because a read is only granted once the buffer is empty or being drained.
    r1_step("yc_w",      1'b1, 1'b1, 6'd3, 7'h55, 1'b0, 2'b10, 1'b1, 7'h33);
    r1_step("yc_r",      1'b1, 1'b0, 6'd3, 7'h00, 1'b1, 2'b10, 1'b1, 7'h33);
    r1_step("yc_gap",    1'b0, 1'b0, 6'd0, 7'h00, 1'b0, 2'b00, 1'b0, 7'h00);
    r1_step("yc_resp",   1'b0, 1'b0, 6'd0, 7'h00, 1'b1, 2'b00, 1'b1, 7'h55);
    r1_step("yc_done",   1'b0, 1'b0, 6'd0, 7'h00, 1'b0, 2'b00, 1'b0, 7'h00);

    // Reset in the cycle after a read grant drops the read and rewinds the pointer.
    idle_all();
    set_req(0, 1'b1, 1'b0, 6'd5, 7'h00, 7'h00);
    #1;
    check("rr_read_ready", req_ready, 2'b01);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rr_in_rst_resp_v", resp_v, 2'b00);
    check("rr_in_rst_ce", ram_ce, 1'b0);
    check("rr_in_rst_ready", req_ready, 2'b00);
    @(negedge clk);
    check("rr_in_rst_ce2", ram_ce, 1'b0);
    reset = 1'b0;
    idle_all();
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("rr_after%0d_resp_v", c), resp_v, 2'b00);
      @(negedge clk);
    end
    set_req(0, 1'b1, 1'b1, 6'd30, 7'h01, 7'h7F);
    set_req(1, 1'b1, 1'b1, 6'd31, 7'h02, 7'h7F);
    #1;
    check("rr_ptr_restart", req_ready, 2'b01);
    @(negedge clk);

    // Randomized phase: seed addresses 0..7 with known words, then reset for a clean start.
    idle_all();
    for (int a = 0; a < 8; a++) begin
      gd = 7'($urandom);
      set_req(0, 1'b1, 1'b1, AW'(a), gd, 7'h7F);
      model_mem[a] = gd;
      @(negedge clk);
    end
    do_reset();
    rr = 0;
    inflight.delete();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, ($urandom_range(0, 99) < 70), 1'($urandom), AW'($urandom_range(0, 7)),
                7'($urandom), 7'($urandom));
        resp_yumi[i] = m_v[i] && 1'($urandom);
      end
      // Reference: who may go, then round-robin from the model pointer.
      for (int i = 0; i < N; i++) begin
        el[i] = req_v[i] && (req_we[i] ||
                (!(inflight.size() > 0 && inflight[0].req == i) && (!m_v[i] || resp_yumi[i])));
      end
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (g < 0 && el[j]) g = j;
      end
      ga = (g >= 0) ? req_addr[g*AW +: AW] : '0;
      gd = (g >= 0) ? req_data[g*B +: B] : '0;
      gm = (g >= 0) ? req_mask[g*B +: B] : '0;
      #1;
      check("rnd_ready", req_ready, (g >= 0) ? (2'b01 << g) : 2'b00);
      check("rnd_ce", ram_ce, g >= 0);
      check("rnd_we", ram_we, (g >= 0) ? req_we[g] : 1'b0);
      check("rnd_addr", ram_addr, ga);
      check("rnd_wd", ram_wd, gd);
      check("rnd_mask", ram_w_mask, gm);
      for (int i = 0; i < N; i++) begin
        check($sformatf("rnd_resp_v%0d", i), resp_v[i], m_v[i]);
        if (m_v[i]) check($sformatf("rnd_resp_d%0d", i), resp_data[i*B +: B], m_d[i]);
      end
      // Advance the model across the clock edge.
      delivered = '0;
      if (inflight.size() > 0) begin
        popped = inflight.pop_front();
        m_v[popped.req] = 1'b1;
        m_d[popped.req] = popped.data;
        delivered[popped.req] = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (!delivered[i] && resp_yumi[i]) m_v[i] = 1'b0;
      end
      if (g >= 0) begin
        if (req_we[g]) model_mem[ga] = (model_mem[ga] & ~gm) | (gd & gm);
        else           inflight.push_back('{req: g, data: model_mem[ga]});
        rr = (g + 1) % N;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
